// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up and register-table sequencer: times PWDN/RESETB, then streams
// 24-bit {reg_addr, data} entries from a table ROM to i2c_master.
module ov5640_cfg_seq #(
    parameter int unsigned REG_NUM  = 256,
    parameter int unsigned PWR_DLY  = 1_000_000,
    parameter int unsigned DLY_UNIT = 50_000,
    parameter int unsigned TIMEOUT  = 200_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [23:0] rom_data,
    output logic [23:0] din,
    output logic        din_vld,
    input  logic        send_done,
    output logic        cam_pwdn,
    output logic        cam_rst_n,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = 8;
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_NUM - 1);

    typedef enum logic [3:0] {
        S_PWR_PD,
        S_PWR_RST,
        S_PWR_WAIT,
        S_FETCH,
        S_DECODE,
        S_SEND,
        S_WAIT,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] dly_cyc;

    logic is_delay_c;
    logic dly_over_c;
    logic pwdn_c;
    logic rst_n_c;
    logic vld_c;
    logic busy_c;
    logic done_c;
    logic err_c;

    // An address of FFFF marks a delay entry; a zero-length delay still spends one cycle.
    assign is_delay_c = (rom_data[23:8] == 16'hFFFF);
    assign dly_over_c = (dly_cyc == '0) || (cnt >= dly_cyc - CNT_W'(1));
    assign rom_addr   = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PWR_PD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_PWR_PD:   if (cnt == PWR_LAST) next_state = S_PWR_RST;
            S_PWR_RST:  if (cnt == PWR_LAST) next_state = S_PWR_WAIT;
            S_PWR_WAIT: if (cnt == PWR_LAST) next_state = S_FETCH;
            S_FETCH:    next_state = S_DECODE;
            S_DECODE:   next_state = is_delay_c ? S_DELAY : S_SEND;
            S_SEND:     next_state = S_WAIT;
            S_WAIT: begin
                if (send_done) begin
                    next_state = S_NEXT;
                end else if (cnt == TO_LAST) begin
                    next_state = S_ERR;
                end
            end
            S_DELAY:    if (dly_over_c) next_state = S_NEXT;
            S_NEXT:     next_state = (idx == IDX_LAST) ? S_DONE : S_FETCH;
            S_DONE:     if (start) next_state = S_FETCH;
            S_ERR:      if (start) next_state = S_FETCH;
            default:    next_state = S_PWR_PD;
        endcase
    end

    // Output values for the state being entered, so the registered pins track the state.
    always_comb begin
        pwdn_c  = 1'b0;
        rst_n_c = 1'b1;
        vld_c   = 1'b0;
        busy_c  = 1'b1;
        done_c  = 1'b0;
        err_c   = 1'b0;
        case (next_state)
            S_PWR_PD: begin
                pwdn_c  = 1'b1;
                rst_n_c = 1'b0;
            end
            S_PWR_RST: rst_n_c = 1'b0;
            S_SEND:    vld_c = 1'b1;
            S_DONE: begin
                busy_c = 1'b0;
                done_c = 1'b1;
            end
            S_ERR: begin
                busy_c = 1'b0;
                err_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            dly_cyc   <= '0;
            din       <= '0;
            din_vld   <= 1'b0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            cfg_busy  <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);
            // Only NEXT advances the index; every other entry into FETCH restarts the table.
            if ((next_state == S_FETCH) && (state != S_FETCH)) begin
                idx <= (state == S_NEXT) ? idx + IDX_W'(1) : '0;
            end
            if (state == S_DECODE) begin
                if (is_delay_c) begin
                    dly_cyc <= CNT_W'(rom_data[7:0]) * CNT_W'(DLY_UNIT);
                end else begin
                    din <= rom_data;
                end
            end
            din_vld   <= vld_c;
            cam_pwdn  <= pwdn_c;
            cam_rst_n <= rst_n_c;
            cfg_busy  <= busy_c;
            cfg_done  <= done_c;
            cfg_err   <= err_c;
        end
    end

endmodule
